// File: rtl/three_eight_strobe_pkg.sv
// Shared definitions for the three_eight_strobe block.
//   state_e       : FSM state encoding (idle, driving a line, all-high gap).
//   code_to_nhot  : maps a 3-bit code k to an active-low one-hot byte with
//                   bit (7-k) low, e.g. 0 -> 8'h7F, 7 -> 8'hFE.
package three_eight_strobe_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StGap
  } state_e;

  function automatic logic [7:0] code_to_nhot(input logic [2:0] code);
    return ~(8'h80 >> code);
  endfunction

endpackage

// File: rtl/three_eight_dec.sv
// Combinational 3-to-8 decoder with active-low one-hot output.
//   code  : binary code in
//   n_dec : active-low one-hot out, bit (7-code) low
module three_eight_dec
  import three_eight_strobe_pkg::*;
(
  input  logic [2:0] code,
  output logic [7:0] n_dec
);

  assign n_dec = code_to_nhot(code);

endmodule

// File: rtl/three_eight_strobe.sv
// Strobed 3-to-8 line driver. Each accepted code pulls one line of n_out low
// for HOLD_CYC cycles, followed by GAP_CYC all-high cycles. A one-entry
// pending register accepts one further code while a strobe is in progress.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   code_in  : code to strobe
//   code_vld : code_in valid
//   code_rdy : block accepts a code this cycle
//   n_out    : registered active-low one-hot lines
//   busy     : high outside IDLE
//   done     : one-cycle pulse after the last gap cycle of each strobe
module three_eight_strobe
  import three_eight_strobe_pkg::*;
#(
  parameter int unsigned HOLD_CYC = 4,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code_in,
  input  logic       code_vld,
  output logic       code_rdy,
  output logic [7:0] n_out,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_CYC - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pend_vld_q, pend_vld_d;
  logic [2:0] pend_code_q, pend_code_d;
  logic [7:0] n_out_q, n_out_d;
  logic       done_q, done_d;
  // Holds code_rdy low until the first edge after reset release.
  logic       rdy_en_q;

  logic       xfer;
  logic [2:0] dec_code;
  logic [7:0] dec_n;

  // A held pending code always takes precedence over code_in.
  assign dec_code = pend_vld_q ? pend_code_q : code_in;

  three_eight_dec u_dec (
    .code  (dec_code),
    .n_dec (dec_n)
  );

  assign code_rdy = rdy_en_q & ~pend_vld_q;
  assign xfer     = code_vld & code_rdy;
  assign n_out    = n_out_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    n_out_d     = n_out_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d = StDrive;
          cnt_d   = HoldLoad;
          n_out_d = dec_n;
        end
      end
      StDrive: begin
        if (xfer) begin
          pend_vld_d  = 1'b1;
          pend_code_d = code_in;
        end
        if (cnt_q == 8'd0) begin
          state_d = StGap;
          cnt_d   = GapLoad;
          n_out_d = 8'hFF;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StGap: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
          if (xfer) begin
            pend_vld_d  = 1'b1;
            pend_code_d = code_in;
          end
        end else begin
          done_d = 1'b1;
          if (pend_vld_q) begin
            // Freeing pending here lets code_rdy rise in the first new DRIVE cycle.
            state_d    = StDrive;
            cnt_d      = HoldLoad;
            n_out_d    = dec_n;
            pend_vld_d = 1'b0;
          end else if (xfer) begin
            // Transfer on the last gap cycle bypasses pending entirely.
            state_d = StDrive;
            cnt_d   = HoldLoad;
            n_out_d = dec_n;
          end else begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            n_out_d = 8'hFF;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
        n_out_d = 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= 3'd0;
      n_out_q     <= 8'hFF;
      done_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
      n_out_q     <= n_out_d;
      done_q      <= done_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_three_eight_strobe.sv
module tb_three_eight_strobe;

  localparam int unsigned Hold = 4;
  localparam int unsigned Gap  = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] code_in = 3'd0;
  logic       code_vld = 1'b0;
  logic       code_rdy;
  logic [7:0] n_out;
  logic       busy;
  logic       done;

  logic [2:0] fcode = 3'd0;
  logic       fvld = 1'b0;
  logic       frdy;
  logic [7:0] fn_out;
  logic       fbusy;
  logic       fdone;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0;

  logic [7:0] sb[$];
  logic       in_strobe = 1'b0;
  logic [7:0] cur = 8'hFF;
  int         run = 0;

  always #5 clk = ~clk;

  three_eight_strobe #(.HOLD_CYC(Hold), .GAP_CYC(Gap)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .code_in  (code_in),
    .code_vld (code_vld),
    .code_rdy (code_rdy),
    .n_out    (n_out),
    .busy     (busy),
    .done     (done)
  );

  three_eight_strobe #(.HOLD_CYC(1), .GAP_CYC(1)) dut_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .code_in  (fcode),
    .code_vld (fvld),
    .code_rdy (frdy),
    .n_out    (fn_out),
    .busy     (fbusy),
    .done     (fdone)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected line pattern: all high except bit (7-k).
  function automatic logic [7:0] model_line(input logic [2:0] k);
    logic [7:0] v;
    v = 8'hFF;
    v[7 - k] = 1'b0;
    return v;
  endfunction

  // Priority re-encoder for active-low lines.
  function automatic logic [2:0] eight_three(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) if (!v[i]) r = 3'(7 - i);
    return r;
  endfunction

  // Scoreboard monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_strobe = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (n_out != 8'hFF) begin
        if (!in_strobe) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 32'(n_out), 32'hFF);
          end else begin
            check("strobe_val", 32'(n_out), 32'(sb.pop_front()));
          end
          cur = n_out;
          in_strobe = 1'b1;
          run = 1;
        end else begin
          check("hold_stable", 32'(n_out), 32'(cur));
          run++;
        end
      end else if (in_strobe) begin
        check("hold_len", 32'(run), 32'(Hold));
        in_strobe = 1'b0;
      end
      if (code_vld && code_rdy) sb.push_back(model_line(code_in));
    end
  end

  // Presents k with code_vld high until it is accepted; returns at posedge+1.
  task automatic send(input logic [2:0] k, output int waited);
    int n;
    n = 0;
    code_in = k;
    code_vld = 1'b1;
    @(negedge clk);
    while (!code_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 32'(code_rdy), 32'd1);
    @(posedge clk);
    #1;
    code_vld = 1'b0;
    waited = n;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    int base;
    logic [7:0] exp_n[7];
    logic       exp_busy[7];
    logic       exp_done[7];
    logic [7:0] exp_n2[5];
    logic       exp_rdy2[5];

    // Reset values and code_rdy rising on the first edge after release.
    @(negedge clk);
    check("rst_n_out", 32'(n_out), 32'hFF);
    check("rst_rdy", 32'(code_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_before_edge", 32'(code_rdy), 32'd0);
    @(posedge clk);
    #1;
    check("rdy_after_edge", 32'(code_rdy), 32'd1);

    // Single strobe of code 2.
    exp_n    = '{8'hDF, 8'hDF, 8'hDF, 8'hDF, 8'hFF, 8'hFF, 8'hFF};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    send(3'd2, w);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("single_n_out", 32'(n_out), 32'(exp_n[i]));
      check("single_busy", 32'(busy), 32'(exp_busy[i]));
      check("single_done", 32'(done), 32'(exp_done[i]));
    end

    // Back-to-back 0 then 7, second presented during DRIVE.
    @(posedge clk);
    #1;
    base = done_cnt;
    send(3'd0, w);
    send(3'd7, w);
    exp_n2   = '{8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFE};
    exp_rdy2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_n_out", 32'(n_out), 32'(exp_n2[i]));
      check("b2b_rdy", 32'(code_rdy), 32'(exp_rdy2[i]));
    end
    check("b2b_busy_between", 32'(busy), 32'd1);
    check("b2b_done_between", 32'(done), 32'd1);
    wait_idle();
    @(negedge clk);
    check("b2b_done_count", 32'(done_cnt - base), 32'd2);

    // Three codes with code_vld held high: third waits for second's DRIVE.
    @(posedge clk);
    #1;
    send(3'd1, w);
    send(3'd2, w);
    check("three_second_wait", 32'(w), 32'd0);
    send(3'd4, w);
    check("three_third_wait", 32'(w), 32'd4);
    wait_idle();
    @(negedge clk);
    check("three_sb_drained", 32'(sb.size()), 32'd0);

    // Transfer exactly on the last gap cycle.
    @(posedge clk);
    #1;
    send(3'd3, w);
    repeat (4) @(posedge clk);
    #1;
    send(3'd5, w);
    check("lastgap_wait", 32'(w), 32'd0);
    @(negedge clk);
    check("lastgap_n_out", 32'(n_out), 32'hFB);
    check("lastgap_busy", 32'(busy), 32'd1);
    check("lastgap_done", 32'(done), 32'd1);
    wait_idle();
    @(negedge clk);

    // Reset during DRIVE cycle 2 with a code pending.
    @(posedge clk);
    #1;
    base = done_cnt;
    send(3'd6, w);
    send(3'd1, w);
    rst_n = 1'b0;
    #1;
    check("abort_n_out", 32'(n_out), 32'hFF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rdy", 32'(code_rdy), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_idle_n_out", 32'(n_out), 32'hFF);
    check("abort_idle_busy", 32'(busy), 32'd0);

    // All codes through the fast instance, re-encoded.
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      fcode = 3'(k);
      fvld = 1'b1;
      @(negedge clk);
      check("fast_rdy", 32'(frdy), 32'd1);
      @(posedge clk);
      #1;
      fvld = 1'b0;
      @(negedge clk);
      check("fast_reencode", 32'(eight_three(fn_out)), 32'(k));
      check("fast_line", 32'(fn_out), 32'(model_line(3'(k))));
      repeat (2) @(posedge clk);
      #1;
      check("fast_idle", 32'(fbusy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/three_eight_strobe.md
THREE_EIGHT_STROBE -- requirements
Module: three_eight_strobe

Interface
REQ-001 Parameter HOLD_CYC, default 4, cycles each decoded line is held low; legal range 1..255.
REQ-002 Parameter GAP_CYC, default 1, all-high cycles after each hold; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 code_in  input  3  binary code to decode.
REQ-006 code_vld  input  1  code_in valid.
REQ-007 code_rdy  output  1  block can accept a code this cycle.
REQ-008 n_out  output  8  registered active-low one-hot line outputs.
REQ-009 busy  output  1  high while in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when a strobe's gap completes.

Function
REQ-011 The block SHALL use this mapping: code k drives n_out[7-k] low and all other bits high, e.g. 3'b000 -> 8'h7F, 3'b111 -> 8'hFE. Re-encoding n_out with the team's eight_three priority encoder therefore returns k.
REQ-012 A transfer SHALL occur on a rising edge where code_vld and code_rdy are both high.
REQ-013 The FSM SHALL have three states: IDLE, DRIVE and GAP.
REQ-014 IDLE -> DRIVE on a transfer; n_out shows the decoded value from the next cycle (1-cycle latency).
REQ-015 DRIVE SHALL last exactly HOLD_CYC cycles, then the FSM moves to GAP.
REQ-016 GAP SHALL last exactly GAP_CYC cycles with n_out = 8'hFF.
REQ-017 On GAP exit, the FSM SHALL go to DRIVE with the pending code if one is held, otherwise to IDLE.
REQ-018 A one-entry pending register SHALL hold a code accepted during DRIVE or GAP.
REQ-019 code_rdy SHALL equal !pend_vld; code_rdy is high in IDLE.
REQ-020 Simultaneous events: a transfer in the last GAP cycle with pending empty SHALL go directly to DRIVE next cycle, with no idle gap and no pending use.
REQ-021 Pending full: code_rdy is low; code_in and code_vld are ignored; no code is lost or overwritten.
REQ-022 Pending SHALL be freed in the cycle it is consumed, so code_rdy rises in the first cycle of the new DRIVE.
REQ-023 done SHALL pulse high for the cycle following the last GAP cycle of every strobe.
REQ-024 busy SHALL be high in DRIVE and GAP, including back-to-back strobes.
REQ-025 The cycle counter SHALL be 8 bits, load HOLD_CYC-1 or GAP_CYC-1 on entry to a state, and count down to 0; it never wraps.
REQ-026 n_out SHALL never show more than one low bit, and SHALL never show a glitch value between strobes.

Reset
REQ-027 With rst_n low, outputs SHALL be: n_out = 8'hFF, code_rdy = 0, busy = 0, done = 0.
REQ-028 With rst_n low, internal state SHALL be: state = IDLE, pend_vld = 0, counter = 0.
REQ-029 Reset asserted mid-DRIVE or mid-GAP SHALL abort immediately: the pending code is discarded and no done pulse is issued.
REQ-030 code_rdy SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-031 The state encoding (IDLE, DRIVE, GAP) and the mapping function (code -> active-low one-hot) SHALL live in the shared combination-logic package.
REQ-032 The combinational decode SHALL be a sub-module three_eight_dec (3-bit in, 8-bit active-low out), instantiated once; its output is registered in the parent.
REQ-033 A single always_ff SHALL hold the FSM and counter; the RTL SHALL be 120-400 lines in total.

Verification
REQ-034 Reset, then code 3'b010 with vld for one cycle, defaults -> n_out = 8'hDF for 4 cycles, then 8'hFF for 1 cycle, then a done pulse, then busy falls.
REQ-035 Back-to-back: codes 0 then 7, the second presented during DRIVE -> 8'h7F x4, 8'hFF x1, 8'hFE x4, 8'hFF x1; exactly two done pulses; code_rdy low only while pending is full.
REQ-036 Three codes 1, 2, 4 with vld held high -> the third waits with code_rdy low until the second begins DRIVE; output order is 8'hBF, 8'hDF, 8'hF7.
REQ-037 Transfer exactly in the last GAP cycle -> the new code drives in the next cycle, with no IDLE cycle between strobes.
REQ-038 rst_n pulsed low at DRIVE cycle 2 with a code pending -> n_out = 8'hFF immediately, no done pulse, and the pending code is never driven.
REQ-039 Loop all 8 codes with HOLD_CYC=1, GAP_CYC=1, feeding n_out through eight_three -> the re-encoded value equals each input code.
